// File: rtl/des_sbox_sequencer_pkg.sv
// Shared DES S-box definitions: the eight substitution tables, the sequencer
// state type and the round-word widths.
// Tables are laid out in the printed DES order: entry index = {row, column}.
// Callers hand a raw 6-bit group to des_sbox_lane, which does the row/column
// split before indexing here.
package des_pkg;

  localparam int DES_EXP_W      = 48;
  localparam int DES_SBOX_OUT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [3:0] DES_SBOX [8][64] = '{
    '{ // S1
      4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7,
      4'h0, 4'hF, 4'h7, 4'h4, 4'hE, 4'h2, 4'hD, 4'h1, 4'hA, 4'h6, 4'hC, 4'hB, 4'h9, 4'h5, 4'h3, 4'h8,
      4'h4, 4'h1, 4'hE, 4'h8, 4'hD, 4'h6, 4'h2, 4'hB, 4'hF, 4'hC, 4'h9, 4'h7, 4'h3, 4'hA, 4'h5, 4'h0,
      4'hF, 4'hC, 4'h8, 4'h2, 4'h4, 4'h9, 4'h1, 4'h7, 4'h5, 4'hB, 4'h3, 4'hE, 4'hA, 4'h0, 4'h6, 4'hD
    },
    '{ // S2
      4'hF, 4'h1, 4'h8, 4'hE, 4'h6, 4'hB, 4'h3, 4'h4, 4'h9, 4'h7, 4'h2, 4'hD, 4'hC, 4'h0, 4'h5, 4'hA,
      4'h3, 4'hD, 4'h4, 4'h7, 4'hF, 4'h2, 4'h8, 4'hE, 4'hC, 4'h0, 4'h1, 4'hA, 4'h6, 4'h9, 4'hB, 4'h5,
      4'h0, 4'hE, 4'h7, 4'hB, 4'hA, 4'h4, 4'hD, 4'h1, 4'h5, 4'h8, 4'hC, 4'h6, 4'h9, 4'h3, 4'h2, 4'hF,
      4'hD, 4'h8, 4'hA, 4'h1, 4'h3, 4'hF, 4'h4, 4'h2, 4'hB, 4'h6, 4'h7, 4'hC, 4'h0, 4'h5, 4'hE, 4'h9
    },
    '{ // S3
      4'hA, 4'h0, 4'h9, 4'hE, 4'h6, 4'h3, 4'hF, 4'h5, 4'h1, 4'hD, 4'hC, 4'h7, 4'hB, 4'h4, 4'h2, 4'h8,
      4'hD, 4'h7, 4'h0, 4'h9, 4'h3, 4'h4, 4'h6, 4'hA, 4'h2, 4'h8, 4'h5, 4'hE, 4'hC, 4'hB, 4'hF, 4'h1,
      4'hD, 4'h6, 4'h4, 4'h9, 4'h8, 4'hF, 4'h3, 4'h0, 4'hB, 4'h1, 4'h2, 4'hC, 4'h5, 4'hA, 4'hE, 4'h7,
      4'h1, 4'hA, 4'hD, 4'h0, 4'h6, 4'h9, 4'h8, 4'h7, 4'h4, 4'hF, 4'hE, 4'h3, 4'hB, 4'h5, 4'h2, 4'hC
    },
    '{ // S4
      4'h7, 4'hD, 4'hE, 4'h3, 4'h0, 4'h6, 4'h9, 4'hA, 4'h1, 4'h2, 4'h8, 4'h5, 4'hB, 4'hC, 4'h4, 4'hF,
      4'hD, 4'h8, 4'hB, 4'h5, 4'h6, 4'hF, 4'h0, 4'h3, 4'h4, 4'h7, 4'h2, 4'hC, 4'h1, 4'hA, 4'hE, 4'h9,
      4'hA, 4'h6, 4'h9, 4'h0, 4'hC, 4'hB, 4'h7, 4'hD, 4'hF, 4'h1, 4'h3, 4'hE, 4'h5, 4'h2, 4'h8, 4'h4,
      4'h3, 4'hF, 4'h0, 4'h6, 4'hA, 4'h1, 4'hD, 4'h8, 4'h9, 4'h4, 4'h5, 4'hB, 4'hC, 4'h7, 4'h2, 4'hE
    },
    '{ // S5
      4'h2, 4'hC, 4'h4, 4'h1, 4'h7, 4'hA, 4'hB, 4'h6, 4'h8, 4'h5, 4'h3, 4'hF, 4'hD, 4'h0, 4'hE, 4'h9,
      4'hE, 4'hB, 4'h2, 4'hC, 4'h4, 4'h7, 4'hD, 4'h1, 4'h5, 4'h0, 4'hF, 4'hA, 4'h3, 4'h9, 4'h8, 4'h6,
      4'h4, 4'h2, 4'h1, 4'hB, 4'hA, 4'hD, 4'h7, 4'h8, 4'hF, 4'h9, 4'hC, 4'h5, 4'h6, 4'h3, 4'h0, 4'hE,
      4'hB, 4'h8, 4'hC, 4'h7, 4'h1, 4'hE, 4'h2, 4'hD, 4'h6, 4'hF, 4'h0, 4'h9, 4'hA, 4'h4, 4'h5, 4'h3
    },
    '{ // S6
      4'hC, 4'h1, 4'hA, 4'hF, 4'h9, 4'h2, 4'h6, 4'h8, 4'h0, 4'hD, 4'h3, 4'h4, 4'hE, 4'h7, 4'h5, 4'hB,
      4'hA, 4'hF, 4'h4, 4'h2, 4'h7, 4'hC, 4'h9, 4'h5, 4'h6, 4'h1, 4'hD, 4'hE, 4'h0, 4'hB, 4'h3, 4'h8,
      4'h9, 4'hE, 4'hF, 4'h5, 4'h2, 4'h8, 4'hC, 4'h3, 4'h7, 4'h0, 4'h4, 4'hA, 4'h1, 4'hD, 4'hB, 4'h6,
      4'h4, 4'h3, 4'h2, 4'hC, 4'h9, 4'h5, 4'hF, 4'hA, 4'hB, 4'hE, 4'h1, 4'h7, 4'h6, 4'h0, 4'h8, 4'hD
    },
    '{ // S7
      4'h4, 4'hB, 4'h2, 4'hE, 4'hF, 4'h0, 4'h8, 4'hD, 4'h3, 4'hC, 4'h9, 4'h7, 4'h5, 4'hA, 4'h6, 4'h1,
      4'hD, 4'h0, 4'hB, 4'h7, 4'h4, 4'h9, 4'h1, 4'hA, 4'hE, 4'h3, 4'h5, 4'hC, 4'h2, 4'hF, 4'h8, 4'h6,
      4'h1, 4'h4, 4'hB, 4'hD, 4'hC, 4'h3, 4'h7, 4'hE, 4'hA, 4'hF, 4'h6, 4'h8, 4'h0, 4'h5, 4'h9, 4'h2,
      4'h6, 4'hB, 4'hD, 4'h8, 4'h1, 4'h4, 4'hA, 4'h7, 4'h9, 4'h5, 4'h0, 4'hF, 4'hE, 4'h2, 4'h3, 4'hC
    },
    '{ // S8
      4'hD, 4'h2, 4'h8, 4'h4, 4'h6, 4'hF, 4'hB, 4'h1, 4'hA, 4'h9, 4'h3, 4'hE, 4'h5, 4'h0, 4'hC, 4'h7,
      4'h1, 4'hF, 4'hD, 4'h8, 4'hA, 4'h3, 4'h7, 4'h4, 4'hC, 4'h5, 4'h6, 4'hB, 4'h0, 4'hE, 4'h9, 4'h2,
      4'h7, 4'hB, 4'h4, 4'h1, 4'h9, 4'hC, 4'hE, 4'h2, 4'h0, 4'h6, 4'hA, 4'hD, 4'hF, 4'h3, 4'h5, 4'h8,
      4'h2, 4'h1, 4'hE, 4'h7, 4'h4, 4'hA, 4'h8, 4'hD, 4'hF, 4'hC, 4'h9, 4'h0, 4'h3, 4'h5, 4'h6, 4'hB
    }
  };

  // Table index for a raw 6-bit group: outer bits pick the row, inner four the column.
  function automatic logic [5:0] des_sbox_index(input logic [5:0] addr);
    return {addr[5], addr[0], addr[4:1]};
  endfunction

endpackage

// File: rtl/des_sbox_sequencer_lane.sv
// One S-box lookup lane: a 3-bit select picks S1..S8, the raw 6-bit group is
// decoded into row/column internally. Purely combinational.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic [5:0] addr_i,
  output logic [3:0] res_o
);

  // Table lookup with row/column decode of the raw group.
  always_comb begin
    res_o = DES_SBOX[sel_i][des_sbox_index(addr_i)];
  end

endmodule

// File: rtl/des_sbox_sequencer.sv
// DES S-box sequencer: walks the eight 6-bit groups of a 48-bit expanded word
// through LANES lookup lanes per cycle and returns the 32-bit S1..S8 result.
//
// state | meaning
// IDLE  | waiting for a word, o_ready high
// RUN   | LANES groups substituted per cycle, idx counts steps
// DONE  | result held on o_data/o_valid until i_ready
//
// Optional feature: define DES_SBOX_SEQ_KEYMIX_EN to add the i_subkey port and
// capture i_data ^ i_subkey instead of i_data. Timing is identical either way.
module des_sbox_sequencer
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DES_EXP_W-1:0]      i_data,
`ifdef DES_SBOX_SEQ_KEYMIX_EN
  input  logic [DES_EXP_W-1:0]      i_subkey,
`endif
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DES_SBOX_OUT_W-1:0] o_data,
  output logic                      o_busy
);

  localparam int         LANE_LG  = $clog2(LANES);
  localparam int         STEPS    = 8 / LANES;
  localparam logic [2:0] LAST_IDX = 3'(STEPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_sequencer: LANES must be 1, 2, 4 or 8");
  end

  seq_state_e                st_q, st_d;
  logic [2:0]                idx_q, idx_d;
  logic [DES_EXP_W-1:0]      opnd_q, opnd_d;
  logic [DES_SBOX_OUT_W-1:0] res_q, res_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;

  logic [DES_EXP_W-1:0]      word_in;
  logic                      accept;
  logic [5:0]                grp [8];
  logic [2:0]                lane_sel [LANES];
  logic [3:0]                lane_res [LANES];

`ifdef DES_SBOX_SEQ_KEYMIX_EN
  assign word_in = i_data ^ i_subkey;
`else
  assign word_in = i_data;
`endif

  for (genvar j = 0; j < 8; j++) begin : g_grp
    assign grp[j] = opnd_q[DES_EXP_W-1-6*j -: 6];
  end

  // Lane k of step idx handles group idx*LANES+k; LANES is a power of two,
  // so the product is a shift and everything stays within 3 bits.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_sel[k] = 3'(idx_q << LANE_LG) | 3'(k);
    des_sbox_lane u_lane (
      .sel_i  (lane_sel[k]),
      .addr_i (grp[lane_sel[k]]),
      .res_o  (lane_res[k])
    );
  end

  // Ready is combinational so a DONE result and a new word can swap in one cycle.
  always_comb begin
    o_ready = (st_q == ST_IDLE) || ((st_q == ST_DONE) && i_ready);
  end

  assign accept = i_valid & o_ready;

  // Next-state, step counter, operand capture and nibble write-back.
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    opnd_d = opnd_q;
    res_d  = res_q;
    case (st_q)
      ST_IDLE: begin
        if (accept) begin
          st_d   = ST_RUN;
          idx_d  = 3'd0;
          opnd_d = word_in;
          res_d  = '0;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < LANES; k++) begin
          for (int j = 0; j < 8; j++) begin
            if (lane_sel[k] == 3'(j)) begin
              res_d[DES_SBOX_OUT_W-1-4*j -: 4] = lane_res[k];
            end
          end
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST_IDX) begin
          st_d  = ST_DONE;
          idx_d = 3'd0;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          if (accept) begin
            st_d   = ST_RUN;
            idx_d  = 3'd0;
            opnd_d = word_in;
            res_d  = '0;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
    valid_d = (st_d == ST_DONE);
    busy_d  = (st_d != ST_IDLE);
  end

  // State and datapath registers; reset drops any partial result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q    <= ST_IDLE;
      idx_q   <= 3'd0;
      opnd_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data  = res_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Bench for des_sbox_sequencer: four instances (LANES = 1, 2, 4, 8) share the
// stimulus; a transaction-level model tracks each one and is compared every
// cycle, and directed vectors carry hand-computed literal expectations.
module tb_des_sbox_sequencer;

  logic        clk;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic [47:0] din;
`ifdef DES_SBOX_SEQ_KEYMIX_EN
  logic [47:0] skey;
`endif

  logic [3:0]  ov;
  logic [3:0]  ordy;
  logic [3:0]  obusy;
  logic [31:0] od [4];

  int n_checks = 0;
  int n_errors = 0;

  // Independent copy of S1..S8: one 64-bit word per row, column 0 in the top nibble.
  logic [63:0] tb_sbox [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    des_sbox_sequencer #(.LANES(1 << gi)) u_dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (vld),
      .o_ready  (ordy[gi]),
      .i_data   (din),
`ifdef DES_SBOX_SEQ_KEYMIX_EN
      .i_subkey (skey),
`endif
      .o_valid  (ov[gi]),
      .i_ready  (rdy),
      .o_data   (od[gi]),
      .o_busy   (obusy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sub_word(input logic [47:0] w);
    logic [31:0] r;
    logic [5:0]  g;
    logic [63:0] rowv;
    int          col;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      g    = w[47-6*j -: 6];
      rowv = tb_sbox[j][{g[5], g[0]}];
      col  = int'(g[4:1]);
      r[31-4*j -: 4] = rowv[63-4*col -: 4];
    end
    return r;
  endfunction

  function automatic logic [47:0] cur_word();
`ifdef DES_SBOX_SEQ_KEYMIX_EN
    return din ^ skey;
`else
    return din;
`endif
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s lanes=%0d got=%h want=%h t=%0t", name, 1 << idx, act, exp, $time);
    end
  endtask

  // Transaction model: 0 idle, 1 running (cnt cycles left), 2 result held.
  int          ph  [4];
  int          cnt [4];
  logic [47:0] mw  [4];
  logic [31:0] md  [4];

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 4; m++) begin
      if (rst) begin
        ph[m]  = 0;
        cnt[m] = 0;
        md[m]  = '0;
      end else begin
        case (ph[m])
          0: if (vld) begin ph[m] = 1; cnt[m] = 8 >> m; mw[m] = cur_word(); end
          1: begin
            cnt[m] = cnt[m] - 1;
            if (cnt[m] == 0) begin ph[m] = 2; md[m] = sub_word(mw[m]); end
          end
          default: if (rdy) begin
            if (vld) begin ph[m] = 1; cnt[m] = 8 >> m; mw[m] = cur_word(); end
            else ph[m] = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 4; m++) begin
        chk("mdl_valid", m, 32'(ov[m]),    32'(ph[m] == 2));
        chk("mdl_busy",  m, 32'(obusy[m]), 32'(ph[m] != 0));
        chk("mdl_ready", m, 32'(ordy[m]),  32'((ph[m] == 0) || (ph[m] == 2 && rdy)));
        if (ph[m] == 2) chk("mdl_data", m, od[m], md[m]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one word with i_ready high and check the per-lane latency (8/LANES)
  // plus the literal result on the one cycle it is valid.
  task automatic run_vec(input logic [47:0] w, input logic [31:0] exp, input string name);
    vld = 1'b1;
    din = w;
    rdy = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) chk({name, "_acc_ready"}, m, 32'(ordy[m]), 32'd1);
    step();
    vld = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk({name, "_busy"},  m, 32'(obusy[m]), 32'd1);
      chk({name, "_ready"}, m, 32'(ordy[m]),  32'd0);
    end
    for (int n = 1; n <= 9; n++) begin
      step();
      #1;
      for (int m = 0; m < 4; m++) begin
        chk({name, "_valid"}, m, 32'(ov[m]), 32'(n == (8 >> m)));
        if (n == (8 >> m)) chk({name, "_data"}, m, od[m], exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vld = 1'b0;
    rdy = 1'b1;
    din = '0;
`ifdef DES_SBOX_SEQ_KEYMIX_EN
    skey = '0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int m = 0; m < 4; m++) begin
      chk("rst_valid", m, 32'(ov[m]),    32'd0);
      chk("rst_data",  m, od[m],         32'h0);
      chk("rst_ready", m, 32'(ordy[m]),  32'd1);
      chk("rst_busy",  m, 32'(obusy[m]), 32'd0);
    end
    rst = 1'b0;
    step();

    run_vec(48'h000000000000, 32'hEFA72C4D, "zero");
    run_vec(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones");
    run_vec(48'h041041041041, 32'h03DDEAD1, "row1");
    run_vec(48'h820820820820, 32'h40DA4917, "row2");
    run_vec(48'h082082082082, 32'h410DC1B2, "col1");

`ifdef DES_SBOX_SEQ_KEYMIX_EN
    skey = 48'hFFFFFFFFFFFF;
    run_vec(48'h000000000000, 32'hD9CE3DCB, "keymix");
    skey = 48'hA5A5A5A5A5A5;
    run_vec(48'hA5A5A5A5A5A5, 32'hEFA72C4D, "keymix_cancel");
    skey = '0;
`else
    run_vec(48'h000000000000, 32'hEFA72C4D, "nokeymix");
`endif

    // Downstream stall: result and valid hold, ready stays low.
    rdy = 1'b0;
    vld = 1'b1;
    din = 48'hFFFFFF000000;
    step();
    vld = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      #1;
      for (int m = 0; m < 4; m++) begin
        chk("stall_valid", m, 32'(ov[m]),   32'd1);
        chk("stall_ready", m, 32'(ordy[m]), 32'd0);
        chk("stall_data",  m, od[m],        32'hD9CE2C4D);
      end
      step();
    end
    run_vec(48'h000000FFFFFF, 32'hEFA73DCB, "swap");

    // Input toggling during RUN must not disturb the captured word.
    rdy = 1'b0;
    vld = 1'b1;
    din = 48'h041041041041;
    step();
    for (int n = 1; n <= 8; n++) begin
      din = {16'($urandom), $urandom};
      vld = n[0];
      step();
    end
    #1;
    for (int m = 0; m < 4; m++) begin
      chk("toggle_valid", m, 32'(ov[m]), 32'd1);
      chk("toggle_data",  m, od[m],      32'h03DDEAD1);
    end
    vld = 1'b0;
    rdy = 1'b1;
    step();
    step();

    // Reset in the third RUN cycle clears everything at once.
    vld = 1'b1;
    din = '0;
    rdy = 1'b1;
    step();
    vld = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk("midrst_valid", m, 32'(ov[m]),    32'd0);
      chk("midrst_data",  m, od[m],         32'h0);
      chk("midrst_ready", m, 32'(ordy[m]),  32'd1);
      chk("midrst_busy",  m, 32'(obusy[m]), 32'd0);
    end
    step();
    rst = 1'b0;
    step();
    run_vec(48'h000000000000, 32'hEFA72C4D, "after_rst");

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
